// File: rtl/sh7034_wdt_pkg.sv
// Shared types and constants for the SH7034 watchdog timer: register layouts,
// init values, write passwords, bus addresses and the CKS prescaler tap table.
package sh7034_wdt_pkg;

  typedef struct packed {
    logic       ovf;
    logic       wt_it;
    logic       tme;
    logic [1:0] rsv;
    logic [2:0] cks;
  } wtcsr_t;

  typedef struct packed {
    logic       wovf;
    logic       rste;
    logic       rsts;
    logic [4:0] rsv;
  } rstcsr_t;

  localparam wtcsr_t  WTCSR_INIT  = 8'h18;
  localparam rstcsr_t RSTCSR_INIT = 8'h1F;

  localparam logic [7:0] PW_5A = 8'h5A;
  localparam logic [7:0] PW_A5 = 8'hA5;

  localparam logic [27:0] ADDR_B8 = 28'h5FF_FFB8;

  typedef enum logic {
    ST_IDLE,
    ST_PULSE
  } pulse_state_t;

  // Number of low prescaler bits that must all be ones for a tick.
  function automatic logic [3:0] cks_tap(input logic [2:0] cks);
    logic [3:0] k;
    case (cks)
      3'd0:    k = 4'd1;
      3'd1:    k = 4'd6;
      3'd2:    k = 4'd7;
      3'd3:    k = 4'd8;
      3'd4:    k = 4'd9;
      3'd5:    k = 4'd10;
      3'd6:    k = 4'd12;
      default: k = 4'd13;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/sh7034_wdt_prescaler.sv
// 13-bit free-running prescaler for the WDT; emits a one-CE_R tick whenever
// the low k bits selected by CKS are all ones.
module sh7034_wdt_prescaler
  import sh7034_wdt_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce_r,
  input  logic       res_n,
  input  logic       tme,
  input  logic [2:0] cks,
  output logic       tick
);

  logic [12:0] cnt;
  logic [12:0] mask;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (!rst_n) begin
      cnt <= '0;
    end else if (ce_r) begin
      if (!res_n || !tme) cnt <= '0;
      else                cnt <= cnt + 13'd1;
    end
  end

  assign mask = 13'((14'd1 << cks_tap(cks)) - 14'd1);
  assign tick = ce_r && res_n && tme && ((cnt & mask) == mask);

endmodule

// File: rtl/sh7034_wdt.sv
// SH7034 watchdog timer: bus decode, WTCSR/WTCNT/RSTCSR with password writes,
// interval interrupt and the watchdog overflow / reset-request pulse FSM.
module sh7034_wdt
  import sh7034_wdt_pkg::*;
#(
  parameter int OVF_PULSE = 128,
  parameter int RST_PULSE = 512
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CE_R,
  input  logic        CE_F,
  input  logic        RES_N,
  input  logic [27:0] IBUS_A,
  input  logic [31:0] IBUS_DI,
  output logic [31:0] IBUS_DO,
  input  logic [3:0]  IBUS_BA,
  input  logic        IBUS_WE,
  input  logic        IBUS_REQ,
  output logic        IBUS_BUSY,
  output logic        IBUS_ACT,
  output logic        WDT_IRQ,
  output logic        WDTOVF_N,
  output logic        WDT_PRES_N,
  output logic        WDT_MRES_N
);

  localparam logic [9:0] OVF_LEN = 10'(OVF_PULSE);
  localparam logic [9:0] RST_LEN = 10'(RST_PULSE);
  localparam logic [9:0] OVF_END = 10'(OVF_PULSE - 1);
  localparam logic [9:0] RST_END = 10'(RST_PULSE - 1);

  wtcsr_t       wtcsr;
  rstcsr_t      rstcsr;
  logic [7:0]   wtcnt;
  logic         ovf_rd;
  pulse_state_t state, state_nx;
  logic [9:0]   pcnt;
  logic [9:0]   pulse_end;
  logic         rst_lat, rsts_lat;
  logic         tick;

  logic wr, wr_b8, wr_ba, rd, rd_csr;
  logic cnt_wr, csr_wr, wovf_clr, rst_wr;
  logic ovf_evt, int_ovf, wdt_ovf, enter, rst_active, force_init;

  sh7034_wdt_prescaler u_prescaler (
    .clk   (CLK),
    .rst_n (RST_N),
    .ce_r  (CE_R),
    .res_n (RES_N),
    .tme   (wtcsr.tme),
    .cks   (wtcsr.cks),
    .tick  (tick)
  );

  assign IBUS_BUSY = 1'b0;
  assign IBUS_ACT  = (IBUS_A[27:2] == ADDR_B8[27:2]);

  // Only exact 16-bit accesses with the right password reach a register.
  assign wr       = CE_R && IBUS_ACT && IBUS_WE && IBUS_REQ;
  assign wr_b8    = wr && (IBUS_A[1:0] == 2'b00) && (IBUS_BA == 4'b1100);
  assign wr_ba    = wr && (IBUS_A[1:0] == 2'b10) && (IBUS_BA == 4'b0011);
  assign cnt_wr   = wr_b8 && (IBUS_DI[31:24] == PW_5A);
  assign csr_wr   = wr_b8 && (IBUS_DI[31:24] == PW_A5);
  assign wovf_clr = wr_ba && (IBUS_DI[15:0] == {PW_A5, 8'h00});
  assign rst_wr   = wr_ba && (IBUS_DI[15:8] == PW_5A);
  assign rd       = CE_F && IBUS_ACT && !IBUS_WE && IBUS_REQ;
  assign rd_csr   = rd && (IBUS_A[1:0] == 2'b00);

  assign ovf_evt    = tick && (wtcnt == 8'hFF) && !cnt_wr;
  assign int_ovf    = ovf_evt && !wtcsr.wt_it;
  assign wdt_ovf    = ovf_evt && wtcsr.wt_it;
  assign enter      = wdt_ovf && (state == ST_IDLE);
  assign rst_active = (state == ST_PULSE) && rst_lat && (pcnt < RST_LEN);
  assign force_init = rst_active || (enter && rstcsr.rste);
  assign pulse_end  = rst_lat ? RST_END : OVF_END;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wtcsr  <= WTCSR_INIT;
      wtcnt  <= 8'h00;
      ovf_rd <= 1'b0;
    end else if (CE_R && (!RES_N || force_init)) begin
      wtcsr  <= WTCSR_INIT;
      wtcnt  <= 8'h00;
      ovf_rd <= 1'b0;
    end else begin
      if (cnt_wr)    wtcnt <= IBUS_DI[23:16];
      else if (tick) wtcnt <= wtcnt + 8'd1;
      if (csr_wr) begin
        wtcsr.wt_it <= IBUS_DI[22];
        wtcsr.tme   <= IBUS_DI[21];
        wtcsr.cks   <= IBUS_DI[18:16];
      end
      // OVF can only be cleared by software that has seen it set.
      if (int_ovf)                              wtcsr.ovf <= 1'b1;
      else if (csr_wr && !IBUS_DI[23] && ovf_rd) wtcsr.ovf <= 1'b0;
      if (csr_wr)                    ovf_rd <= 1'b0;
      else if (rd_csr && wtcsr.ovf)  ovf_rd <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rstcsr <= RSTCSR_INIT;
    end else if (CE_R) begin
      if (!RES_N) begin
        rstcsr <= RSTCSR_INIT;
      end else begin
        if (wdt_ovf)       rstcsr.wovf <= 1'b1;
        else if (wovf_clr) rstcsr.wovf <= 1'b0;
        if (rst_wr) begin
          rstcsr.rste <= IBUS_DI[6];
          rstcsr.rsts <= IBUS_DI[5];
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)              IBUS_DO <= '0;
    else if (CE_R && !RES_N) IBUS_DO <= '0;
    else if (rd)             IBUS_DO <= {8'(wtcsr | 8'h18), wtcnt, 8'hFF, 8'(rstcsr | 8'h1F)};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)     state <= ST_IDLE;
    else if (CE_R)  state <= state_nx;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nx and no latch is inferred.
    state_nx = state;
    if (!RES_N) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (wdt_ovf) state_nx = ST_PULSE;
        ST_PULSE: if (pcnt == pulse_end) state_nx = ST_IDLE;
        default:  state_nx = ST_IDLE;
      endcase
    end
  end

  // RSTE/RSTS are sampled every idle cycle, so the entry cycle captures them.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pcnt     <= '0;
      rst_lat  <= 1'b0;
      rsts_lat <= 1'b0;
    end else if (CE_R) begin
      if (!RES_N || state == ST_IDLE) begin
        pcnt     <= '0;
        rst_lat  <= RES_N && rstcsr.rste;
        rsts_lat <= rstcsr.rsts;
      end else begin
        pcnt <= pcnt + 10'd1;
      end
    end
  end

  always_comb begin
    WDTOVF_N   = !((state == ST_PULSE) && (pcnt < OVF_LEN));
    WDT_PRES_N = !(rst_active && !rsts_lat);
    WDT_MRES_N = !(rst_active && rsts_lat);
    WDT_IRQ    = wtcsr.ovf && !wtcsr.wt_it;
  end

endmodule
